mm_uart_loader: RTL

MM_UART_LOADER -- requirements
Module: mm_uart_loader

---
 rtl/mm_uart_loader.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/mm_uart_loader.sv
// Boot loader: pulls a length-prefixed, checksummed word image from a memory-mapped
// UART into memory, then reports ACK/NAK back over the UART.
module mm_uart_loader #(
   parameter int                    DATA_WIDTH    = 32,
   parameter logic [DATA_WIDTH-1:0] RX_ADDR       = 32'h9000_0010,
   parameter logic [DATA_WIDTH-1:0] RX_READY_ADDR = 32'h9000_0014,
   parameter logic [DATA_WIDTH-1:0] TX_ADDR       = 32'h9000_0020,
   parameter logic [DATA_WIDTH-1:0] TX_READY_ADDR = 32'h9000_0024,
   parameter logic [DATA_WIDTH-1:0] MEM_BASE      = 32'h0000_0000,
   parameter int                    MAX_WORDS     = 1024
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   output logic [DATA_WIDTH-1:0] uart_addr,
   output logic                  uart_we,
   output logic [DATA_WIDTH-1:0] uart_wdata,
   input  logic [DATA_WIDTH-1:0] uart_rdata,
   output logic                  mem_we,
   output logic [DATA_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic                  busy,
   output logic                  done,
   output logic                  error
);
   // state     | meaning
   // IDLE      | waiting for start
   // POLL_RX   | polling RX status for an available byte
   // READ_RX   | one-cycle pop of the RX data register
   // WRITE_MEM | one-cycle memory write of the assembled word
   // POLL_TX   | polling TX status for FIFO space
   // SEND      | one-cycle write of the ACK/NAK status byte
   // DONE      | load succeeded, set done
   // ERROR     | load failed, set error
   typedef enum logic [2:0] {
      IDLE, POLL_RX, READ_RX, WRITE_MEM, POLL_TX, SEND, DONE, ERROR
   } state_t;

   typedef enum logic [1:0] {PH_LEN, PH_DATA, PH_CSUM} phase_t;

   localparam logic [7:0] ACK = 8'h06;
   localparam logic [7:0] NAK = 8'h15;

   state_t      state, state_d;
   phase_t      phase;
   logic [1:0]  byte_idx;
   logic [31:0] word_buf;
   logic [31:0] len;
   logic [31:0] word_idx;
   logic [7:0]  cksum;
   logic [7:0]  status;
   logic        done_q, error_q;

   logic [7:0]  rx_byte;
   logic [31:0] full_word;
   logic        len_bad;
   logic        unused_rdata;

   assign rx_byte      = uart_rdata[7:0];
   assign full_word    = {rx_byte, word_buf[23:0]};
   assign len_bad      = (full_word == 32'd0) || (full_word > 32'(MAX_WORDS));
   assign unused_rdata = ^uart_rdata[DATA_WIDTH-1:8];

   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_d;
   end

   always_comb begin
      state_d = state;
      case (state)
         IDLE:      if (start) state_d = POLL_RX;
         POLL_RX:   if (uart_rdata[0]) state_d = READ_RX;
         READ_RX: begin
            case (phase)
               PH_LEN:  state_d = (byte_idx == 2'd3 && len_bad) ? POLL_TX : POLL_RX;
               PH_DATA: state_d = (byte_idx == 2'd3) ? WRITE_MEM : POLL_RX;
               default: state_d = POLL_TX;
            endcase
         end
         WRITE_MEM: state_d = POLL_RX;
         POLL_TX:   if (uart_rdata[0]) state_d = SEND;
         SEND:      state_d = (status == ACK) ? DONE : ERROR;
         DONE:      state_d = IDLE;
         ERROR:     state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         phase    <= PH_LEN;
         byte_idx <= 2'd0;
         word_buf <= 32'd0;
         len      <= 32'd0;
         word_idx <= 32'd0;
         cksum    <= 8'd0;
         status   <= 8'd0;
         done_q   <= 1'b0;
         error_q  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  done_q   <= 1'b0;
                  error_q  <= 1'b0;
                  byte_idx <= 2'd0;
                  word_idx <= 32'd0;
                  cksum    <= 8'd0;
                  phase    <= PH_LEN;
               end
            end
            READ_RX: begin
               word_buf[{byte_idx, 3'b000} +: 8] <= rx_byte;
               byte_idx <= byte_idx + 2'd1;
               case (phase)
                  PH_LEN: begin
                     if (byte_idx == 2'd3) begin
                        len <= full_word;
                        if (len_bad) status <= NAK;
                        else         phase  <= PH_DATA;
                     end
                  end
                  PH_DATA: cksum  <= cksum + rx_byte;
                  default: status <= (rx_byte == cksum) ? ACK : NAK;
               endcase
            end
            WRITE_MEM: begin
               word_idx <= word_idx + 32'd1;
               if (word_idx + 32'd1 == len) phase <= PH_CSUM;
            end
            DONE:    done_q  <= 1'b1;
            ERROR:   error_q <= 1'b1;
            default: ;
         endcase
      end
   end

   // Outputs are forced low while reset is high so a mid-transfer reset never
   // leaks a partial strobe.
   always_comb begin
      uart_addr  = '0;
      uart_we    = 1'b0;
      uart_wdata = '0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      busy       = (state != IDLE);
      done       = done_q;
      error      = error_q;
      case (state)
         POLL_RX: uart_addr = RX_READY_ADDR;
         READ_RX: uart_addr = RX_ADDR;
         POLL_TX: uart_addr = TX_READY_ADDR;
         SEND: begin
            uart_addr  = TX_ADDR;
            uart_we    = 1'b1;
            uart_wdata = DATA_WIDTH'(status);
         end
         WRITE_MEM: begin
            mem_we    = 1'b1;
            mem_addr  = MEM_BASE + DATA_WIDTH'({word_idx[29:0], 2'b00});
            mem_wdata = DATA_WIDTH'(word_buf);
         end
         default: ;
      endcase
      if (reset) begin
         uart_addr  = '0;
         uart_we    = 1'b0;
         uart_wdata = '0;
         mem_we     = 1'b0;
         mem_addr   = '0;
         mem_wdata  = '0;
         busy       = 1'b0;
         done       = 1'b0;
         error      = 1'b0;
      end
   end
endmodule
